// File: rtl/tick_bcd_counter.sv
// Two-channel packed-BCD event counter: channel R counts synchronized raw_in rising edges,
// channel D counts debouncer ticks. Each channel has a sticky overflow flag.
module tick_bcd_counter #(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  raw_in,
    input  logic                  db_tick,
    output logic [4*DIGITS-1:0]   raw_cnt,
    output logic [4*DIGITS-1:0]   db_cnt,
    output logic                  raw_ovf,
    output logic                  db_ovf
);

    localparam int unsigned W = 4 * DIGITS;

    // Returns {all_nines, incremented value}; the value is 0 when all digits were 9.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] nxt;
        logic         carry;
        logic [3:0]   digit;
        nxt   = '0;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = v[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    nxt[4*i +: 4] = 4'd0;
                end else begin
                    nxt[4*i +: 4] = digit + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                nxt[4*i +: 4] = digit;
            end
        end
        return {carry, nxt};
    endfunction

    // Synchronizer (s1, s2) plus edge-detect history (s3); unaffected by clr.
    logic s1, s2, s3;
    logic raw_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign raw_tick = s2 & ~s3;

    // Index 0 is channel R, index 1 is channel D.
    logic [1:0][W-1:0] cnt_q, cnt_d;
    logic [1:0]        ovf_q, ovf_d;
    logic [1:0]        tick;
    logic [1:0][W:0]   inc;

    assign tick = {db_tick, raw_tick};

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        inc   = '0;
        for (int ch = 0; ch < 2; ch++) begin
            inc[ch] = bcd_inc(cnt_q[ch]);
            if (clr) begin
                cnt_d[ch] = '0;
                ovf_d[ch] = 1'b0;
            end else if (tick[ch]) begin
                if (inc[ch][W]) begin
                    ovf_d[ch] = 1'b1;
                    cnt_d[ch] = WRAP ? '0 : cnt_q[ch];
                end else begin
                    cnt_d[ch] = inc[ch][W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign raw_cnt = cnt_q[0];
    assign db_cnt  = cnt_q[1];
    assign raw_ovf = ovf_q[0];
    assign db_ovf  = ovf_q[1];

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter: a wrapping instance and a saturating instance share
// all inputs. Inputs are driven and outputs sampled on the falling edge.
module tb_tick_bcd_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       raw_in = 1'b0;
    logic       db_tick = 1'b0;
    logic [7:0] raw_cnt, db_cnt, s_raw_cnt, s_db_cnt;
    logic       raw_ovf, db_ovf, s_raw_ovf, s_db_ovf;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    tick_bcd_counter #(.DIGITS(2), .WRAP(1'b1)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .raw_in  (raw_in),
        .db_tick (db_tick),
        .raw_cnt (raw_cnt),
        .db_cnt  (db_cnt),
        .raw_ovf (raw_ovf),
        .db_ovf  (db_ovf)
    );

    tick_bcd_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .raw_in  (raw_in),
        .db_tick (db_tick),
        .raw_cnt (s_raw_cnt),
        .db_cnt  (s_db_cnt),
        .raw_ovf (s_raw_ovf),
        .db_ovf  (s_db_ovf)
    );

    task automatic pulse_db(input int n);
        for (int i = 0; i < n; i++) begin
            db_tick = 1'b1;
            @(negedge clk);
            db_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            raw_in  = ~raw_in;
            db_tick = ~db_tick;
            clr     = (i == 2);
        end
        @(negedge clk);
        checks++;
        if ({raw_cnt, db_cnt, raw_ovf, db_ovf} !== 18'h0) begin
            failures++;
            $display("FAIL reset_held got=%h/%h/%b/%b exp=0", raw_cnt, db_cnt, raw_ovf, db_ovf);
        end
        checks++;
        if ({s_raw_cnt, s_db_cnt, s_raw_ovf, s_db_ovf} !== 18'h0) begin
            failures++;
            $display("FAIL reset_held_sat got=%h/%h exp=0", s_raw_cnt, s_db_cnt);
        end
        raw_in  = 1'b0;
        db_tick = 1'b0;
        clr     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({raw_cnt, db_cnt, raw_ovf, db_ovf} !== 18'h0) begin
            failures++;
            $display("FAIL reset_idle got=%h/%h/%b/%b exp=0", raw_cnt, db_cnt, raw_ovf, db_ovf);
        end
    endtask

    task automatic test_db_single();
        db_tick = 1'b1;
        @(negedge clk);
        db_tick = 1'b0;
        checks++;
        if (db_cnt !== 8'h01) begin
            failures++;
            $display("FAIL db_single got=%h exp=01", db_cnt);
        end
        checks++;
        if (raw_cnt !== 8'h00) begin
            failures++;
            $display("FAIL db_single_raw got=%h exp=00", raw_cnt);
        end
    endtask

    task automatic test_raw_bounce();
        for (int r = 0; r < 2; r++) begin
            raw_in = 1'b1;
            repeat (3) @(negedge clk);
            raw_in = 1'b0;
            repeat (3) @(negedge clk);
        end
        raw_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (raw_cnt !== 8'h02) begin
            failures++;
            $display("FAIL raw_before_latency got=%h exp=02", raw_cnt);
        end
        @(negedge clk);
        checks++;
        if (raw_cnt !== 8'h03) begin
            failures++;
            $display("FAIL raw_after_latency got=%h exp=03", raw_cnt);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (raw_cnt !== 8'h03 || raw_ovf !== 1'b0) begin
            failures++;
            $display("FAIL raw_held got=%h ovf=%b exp=03 ovf=0", raw_cnt, raw_ovf);
        end
        raw_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_db_count();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pulse_db(9);
        checks++;
        if (db_cnt !== 8'h09) begin
            failures++;
            $display("FAIL db_nine got=%h exp=09", db_cnt);
        end
        pulse_db(1);
        checks++;
        if (db_cnt !== 8'h10) begin
            failures++;
            $display("FAIL db_ten got=%h exp=10", db_cnt);
        end
        pulse_db(89);
        checks++;
        if (db_cnt !== 8'h99 || db_ovf !== 1'b0) begin
            failures++;
            $display("FAIL db_full got=%h ovf=%b exp=99 ovf=0", db_cnt, db_ovf);
        end
        pulse_db(1);
        checks++;
        if (db_cnt !== 8'h00 || db_ovf !== 1'b1) begin
            failures++;
            $display("FAIL db_wrap got=%h ovf=%b exp=00 ovf=1", db_cnt, db_ovf);
        end
        checks++;
        if (s_db_cnt !== 8'h99 || s_db_ovf !== 1'b1) begin
            failures++;
            $display("FAIL db_sat got=%h ovf=%b exp=99 ovf=1", s_db_cnt, s_db_ovf);
        end
        pulse_db(1);
        checks++;
        if (db_cnt !== 8'h01 || db_ovf !== 1'b1) begin
            failures++;
            $display("FAIL db_sticky got=%h ovf=%b exp=01 ovf=1", db_cnt, db_ovf);
        end
        checks++;
        if (s_db_cnt !== 8'h99) begin
            failures++;
            $display("FAIL db_sat_hold got=%h exp=99", s_db_cnt);
        end
    endtask

    task automatic test_clr_priority();
        pulse_db(41);
        checks++;
        if (db_cnt !== 8'h42) begin
            failures++;
            $display("FAIL db_42 got=%h exp=42", db_cnt);
        end
        clr     = 1'b1;
        db_tick = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        db_tick = 1'b0;
        checks++;
        if (db_cnt !== 8'h00 || db_ovf !== 1'b0) begin
            failures++;
            $display("FAIL clr_prio got=%h ovf=%b exp=00 ovf=0", db_cnt, db_ovf);
        end
        checks++;
        if (s_db_cnt !== 8'h00 || s_db_ovf !== 1'b0) begin
            failures++;
            $display("FAIL clr_prio_sat got=%h ovf=%b exp=00 ovf=0", s_db_cnt, s_db_ovf);
        end
        pulse_db(1);
        checks++;
        if (db_cnt !== 8'h01) begin
            failures++;
            $display("FAIL clr_next got=%h exp=01", db_cnt);
        end
    endtask

    task automatic test_back_to_back();
        db_tick = 1'b1;
        repeat (5) @(negedge clk);
        db_tick = 1'b0;
        checks++;
        if (db_cnt !== 8'h06) begin
            failures++;
            $display("FAIL db_held got=%h exp=06", db_cnt);
        end
    endtask

    task automatic test_async_reset();
        pulse_db(51);
        raw_in = 1'b1;
        repeat (3) @(negedge clk);
        raw_in = 1'b0;
        checks++;
        if (db_cnt !== 8'h57 || raw_cnt !== 8'h01) begin
            failures++;
            $display("FAIL pre_reset got=%h/%h exp=01/57", raw_cnt, db_cnt);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({raw_cnt, db_cnt, raw_ovf, db_ovf} !== 18'h0) begin
            failures++;
            $display("FAIL async_reset got=%h/%h/%b/%b exp=0", raw_cnt, db_cnt, raw_ovf, db_ovf);
        end
        @(negedge clk);
        reset = 1'b1;
        pulse_db(1);
        checks++;
        if (db_cnt !== 8'h01) begin
            failures++;
            $display("FAIL resume_db got=%h exp=01", db_cnt);
        end
        raw_in = 1'b1;
        repeat (3) @(negedge clk);
        raw_in = 1'b0;
        checks++;
        if (raw_cnt !== 8'h01) begin
            failures++;
            $display("FAIL resume_raw got=%h exp=01", raw_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_db_single();
        test_raw_bounce();
        test_db_count();
        test_clr_priority();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
